// File: rtl/pc_pkg.sv
// pc_pkg: shared update-cause enum, default parameters and RAS width helper for pc_unit.
package pc_pkg;
  typedef enum logic [2:0] {
    PC_HOLD,
    PC_SEQ,
    PC_BRANCH,
    PC_CALL,
    PC_RET
  } pc_cause_e;
  localparam int PC_W_DEF      = 8;
  localparam int INC_DEF       = 4;
  localparam int RESET_PC_DEF  = 0;
  localparam int RAS_DEPTH_DEF = 4;
  function automatic int depth_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: request/redirect bus between branch resolution (master) and the pc unit (slave).
interface pc_unit_if #(parameter int PC_W = pc_pkg::PC_W_DEF);
  logic            E;
  logic            branch_taken;
  logic            call;
  logic            ret;
  logic [PC_W-1:0] branch_target;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus;
  logic            redirect;
  logic            ras_empty;
  logic            ras_full;
  logic            ras_err;
  modport master (
    output E, branch_taken, call, ret, branch_target,
    input  pc, pc_plus, redirect, ras_empty, ras_full, ras_err
  );
  modport slave (
    input  E, branch_taken, call, ret, branch_target,
    output pc, pc_plus, redirect, ras_empty, ras_full, ras_err
  );
endinterface

// File: rtl/pc_unit_return_stack.sv
// return_stack: circular LIFO of return addresses; a push when full overwrites the oldest entry.
module return_stack
  import pc_pkg::*;
#(
  parameter int W     = PC_W_DEF,
  parameter int DEPTH = RAS_DEPTH_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty,
  output logic         overflow,
  output logic         underflow
);
  localparam int AW = depth_w(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] ptr;
  logic [AW-1:0] ptr_inc;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;
  assign ptr_inc   = ptr + 1'b1;
  assign empty     = cnt == '0;
  assign full      = cnt == (AW+1)'(DEPTH);
  assign overflow  = push & full;
  assign underflow = pop & empty;
  assign do_push   = push & ~pop;
  assign do_pop    = pop & ~empty;
  assign top       = mem[ptr];
  // pointer wraps modulo DEPTH so a full push lands on the oldest slot
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ptr <= '0;
      cnt <= '0;
    end else if (do_push) begin
      ptr <= ptr_inc;
      cnt <= full ? cnt : cnt + 1'b1;
    end else if (do_pop) begin
      ptr <= ptr - 1'b1;
      cnt <= cnt - 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem[ptr_inc] <= din;
endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with prioritised ret/call/branch redirects.
// Define PC_RAS_EN to build the return-address stack; otherwise call acts as branch and ret is ignored.
module pc_unit
  import pc_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int INC       = INC_DEF,
  parameter int RESET_PC  = RESET_PC_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input logic       clk,
  input logic       reset,
  pc_unit_if.slave  bus
);
  localparam logic [PC_W-1:0] INC_V = PC_W'(INC);
  pc_cause_e       cause;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_n;
  logic [PC_W-1:0] pc_plus;
  logic [PC_W-1:0] top;
  logic            redirect_q;
  logic            redirect_n;
  logic            err_q;
  logic            err_n;
  assign pc_plus      = pc_q + INC_V;
  assign bus.pc       = pc_q;
  assign bus.pc_plus  = pc_plus;
  assign bus.redirect = redirect_q;
  assign bus.ras_err  = err_q;
`ifdef PC_RAS_EN
  logic empty;
  logic full;
  logic overflow;
  logic underflow;
  // a ret on an empty stack falls back to sequential and only flags underflow
  always_comb
    cause = !bus.E ? PC_HOLD :
            bus.ret ? (empty ? PC_SEQ : PC_RET) :
            bus.call ? PC_CALL :
            bus.branch_taken ? PC_BRANCH : PC_SEQ;
  return_stack #(.W(PC_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (cause == PC_CALL),
    .pop       (bus.E & bus.ret),
    .din       (pc_plus),
    .top       (top),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );
  assign bus.ras_empty = empty;
  assign bus.ras_full  = full;
  assign err_n         = overflow | underflow;
`else
  logic unused_ret;
  assign unused_ret = bus.ret;
  always_comb
    cause = !bus.E ? PC_HOLD :
            (bus.call | bus.branch_taken) ? PC_BRANCH : PC_SEQ;
  assign top           = '0;
  assign bus.ras_empty = 1'b1;
  assign bus.ras_full  = 1'b0;
  assign err_n         = 1'b0;
`endif
  always_comb begin
    pc_n       = cause == PC_HOLD ? pc_q :
                 cause == PC_SEQ  ? pc_plus :
                 cause == PC_RET  ? top : bus.branch_target;
    redirect_n = cause == PC_HOLD ? redirect_q : cause != PC_SEQ;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc_q       <= PC_W'(RESET_PC);
      redirect_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      pc_q       <= pc_n;
      redirect_q <= redirect_n;
      err_q      <= err_n;
    end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vectors with a scoreboard queue checked by a negedge monitor.
module tb_pc_unit;
  typedef struct {
    logic [7:0] pc;
    logic       redir;
    logic       empty;
    logic       full;
    logic       err;
    string      tag;
  } exp_t;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  pc_unit_if #(.PC_W(8)) bus ();
  pc_unit #(.PC_W(8), .INC(4), .RESET_PC(0), .RAS_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask
  always @(negedge clk)
    if (sb.size() > 0) begin : mon
      exp_t x;
      x = sb.pop_front();
      cmp({x.tag, ".pc"}, bus.pc, x.pc);
      cmp({x.tag, ".pc_plus"}, bus.pc_plus, x.pc + 8'd4);
      cmp({x.tag, ".redirect"}, {7'd0, bus.redirect}, {7'd0, x.redir});
      cmp({x.tag, ".ras_empty"}, {7'd0, bus.ras_empty}, {7'd0, x.empty});
      cmp({x.tag, ".ras_full"}, {7'd0, bus.ras_full}, {7'd0, x.full});
      cmp({x.tag, ".ras_err"}, {7'd0, bus.ras_err}, {7'd0, x.err});
    end
  task automatic step(input logic e, br, cl, rt, input logic [7:0] tgt,
                      input logic [7:0] xpc, input logic xr, xe, xf, xerr, input string tag);
    bus.E = e;
    bus.branch_taken = br;
    bus.call = cl;
    bus.ret = rt;
    bus.branch_target = tgt;
    @(posedge clk);
    #1;
    sb.push_back('{xpc, xr, xe, xf, xerr, tag});
  endtask
  task automatic async_reset();
    #6;
    reset = 1'b1;
    #1;
    cmp("async.pc", bus.pc, 8'h00);
    cmp("async.redirect", {7'd0, bus.redirect}, 8'd0);
    cmp("async.ras_empty", {7'd0, bus.ras_empty}, 8'd1);
    cmp("async.ras_full", {7'd0, bus.ras_full}, 8'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1'b1;
    bus.E = 1'b0;
    bus.branch_taken = 1'b0;
    bus.call = 1'b0;
    bus.ret = 1'b0;
    bus.branch_target = 8'h00;
    sb.push_back('{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, "reset"});
    #12;
    reset = 1'b0;
    step(1, 0, 0, 0, 8'h00, 8'h04, 0, 1, 0, 0, "seq1");
    step(1, 0, 0, 0, 8'h00, 8'h08, 0, 1, 0, 0, "seq2");
    step(1, 0, 0, 0, 8'h00, 8'h0C, 0, 1, 0, 0, "seq3");
    step(1, 1, 0, 0, 8'hFC, 8'hFC, 1, 1, 0, 0, "br_fc");
    step(1, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, "wrap");
    step(0, 1, 0, 0, 8'h55, 8'h00, 0, 1, 0, 0, "stall1");
    step(0, 1, 0, 0, 8'h55, 8'h00, 0, 1, 0, 0, "stall2");
    step(1, 1, 0, 0, 8'h55, 8'h55, 1, 1, 0, 0, "br_after_stall");
    step(1, 0, 0, 0, 8'h00, 8'h59, 0, 1, 0, 0, "seq_after_br");
`ifdef PC_RAS_EN
    step(1, 1, 0, 0, 8'h10, 8'h10, 1, 1, 0, 0, "br10");
    step(1, 0, 1, 0, 8'h40, 8'h40, 1, 0, 0, 0, "call40");
    step(1, 0, 0, 1, 8'h00, 8'h14, 1, 1, 0, 0, "ret14");
    step(1, 0, 1, 0, 8'h20, 8'h20, 1, 0, 0, 0, "call_a");
    step(1, 0, 1, 0, 8'h30, 8'h30, 1, 0, 0, 0, "call_b");
    step(1, 0, 1, 0, 8'h50, 8'h50, 1, 0, 0, 0, "call_c");
    step(1, 0, 1, 0, 8'h60, 8'h60, 1, 0, 1, 0, "call_d_full");
    step(1, 0, 1, 0, 8'h70, 8'h70, 1, 0, 1, 1, "call_e_ovf");
    step(1, 0, 0, 1, 8'h00, 8'h64, 1, 0, 0, 0, "ret_e");
    step(1, 0, 0, 1, 8'h00, 8'h54, 1, 0, 0, 0, "ret_d");
    step(1, 0, 0, 1, 8'h00, 8'h34, 1, 0, 0, 0, "ret_c");
    step(1, 0, 0, 1, 8'h00, 8'h24, 1, 1, 0, 0, "ret_b");
    step(1, 0, 0, 1, 8'h00, 8'h28, 0, 1, 0, 1, "ret_unf");
    step(0, 0, 0, 1, 8'h00, 8'h28, 0, 1, 0, 0, "hold_clr_err");
    step(1, 1, 0, 0, 8'h2C, 8'h2C, 1, 1, 0, 0, "br2c");
    step(1, 0, 1, 0, 8'h80, 8'h80, 1, 0, 0, 0, "call80");
    step(1, 0, 1, 1, 8'h90, 8'h30, 1, 1, 0, 0, "ret_call");
    step(1, 0, 0, 1, 8'h00, 8'h34, 0, 1, 0, 1, "ret_unf2");
    step(1, 0, 1, 0, 8'hA0, 8'hA0, 1, 0, 0, 0, "call_a0");
    async_reset();
    step(1, 0, 0, 1, 8'h00, 8'h04, 0, 1, 0, 1, "ret_after_rst");
`else
    step(1, 0, 1, 0, 8'h10, 8'h10, 1, 1, 0, 0, "call_as_br");
    step(1, 0, 0, 1, 8'h00, 8'h14, 0, 1, 0, 0, "ret_ignored");
    step(1, 1, 0, 1, 8'h80, 8'h80, 1, 1, 0, 0, "ret_br");
    step(1, 0, 1, 1, 8'h90, 8'h90, 1, 1, 0, 0, "ret_call");
    step(0, 0, 0, 1, 8'h00, 8'h90, 1, 1, 0, 0, "ret_hold");
    step(1, 1, 0, 0, 8'hA0, 8'hA0, 1, 1, 0, 0, "br_a0");
    async_reset();
    step(1, 0, 0, 0, 8'h00, 8'h04, 0, 1, 0, 0, "seq_after_rst");
`endif
    bus.E = 1'b0;
    bus.branch_taken = 1'b0;
    bus.call = 1'b0;
    bus.ret = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
